// File: rtl/cfg_cmd_pkg.sv
// Shared types for the host config-write path: command word layout, opcodes,
// dispatcher FSM states and the voice-operator address geometry.
package cfg_cmd_pkg;

  localparam int NUM_VOICE_OPERATORS = 16;
  localparam int VOICE_OPERATOR_ID_W = 4;
  localparam int CMD_ADDR_W          = 12;
  localparam int CMD_DATA_W          = 16;
  localparam int NOTE_ON_ADDR        = 0;

  typedef enum logic [3:0] {
    OP_NOP             = 4'h0,
    OP_PHASE_STEP      = 4'h1,
    OP_NOTE_ON_SET     = 4'h2,
    OP_NOTE_ON_CLEAR   = 4'h3,
    OP_NOTE_ON_ALL     = 4'h4,
    OP_PHASE_STEP_FILL = 4'h5,
    OP_CLEAR_ERROR     = 4'hF
  } cmd_op_e;

  // op stays a raw nibble so illegal host opcodes survive the FIFO intact.
  typedef struct packed {
    logic [3:0]            op;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] data;
  } cmd_word_t;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_FILL = 2'd2
  } disp_state_e;

endpackage

// File: rtl/config_cmd_fifo.sv
// Small synchronous FIFO of host command words. The head entry is read
// straight out of the storage flops so the dispatcher can decode it in-cycle.
module config_cmd_fifo
  import cfg_cmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      i_Clock,
  input  logic      i_Reset,
  input  logic      i_Push,
  input  cmd_word_t i_PushData,
  input  logic      i_Pop,
  output cmd_word_t o_PopData,
  output logic      o_Full,
  output logic      o_Empty
);

  localparam int PTR_W = $clog2(DEPTH);

  cmd_word_t        mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W:0]   count;
  logic             doPush;
  logic             doPop;

  assign doPush    = i_Push && !o_Full;
  assign doPop     = i_Pop && !o_Empty;
  assign o_Full    = (count == (PTR_W+1)'(DEPTH));
  assign o_Empty   = (count == '0);
  assign o_PopData = mem[rdPtr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_Clock) begin
    if (doPush) mem[wrPtr] <= i_PushData;
  end

endmodule

// File: rtl/config_write_dispatcher.sv
// Host command dispatcher: queues 32-bit commands, keeps the NoteOn shadow and
// drives at most one registered PhaseStep or NoteOn config write per clock.
module config_write_dispatcher
  import cfg_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_VOICES = 12,
  parameter int NUM_OPS    = NUM_VOICE_OPERATORS
) (
  input  logic                           i_Clock,
  input  logic                           i_Reset,
  input  logic                           i_CmdValid,
  output logic                           o_CmdReady,
  input  logic [31:0]                    i_CmdData,
  output logic                           o_PhaseStepConfigWriteEnable,
  output logic                           o_NoteOnConfigWriteEnable,
  output logic [VOICE_OPERATOR_ID_W-1:0] o_ConfigWriteAddr,
  output logic [15:0]                    o_ConfigWriteData,
  output logic                           o_Busy,
  output logic                           o_CmdError
);

  localparam logic [CMD_ADDR_W-1:0]          OPS_LIMIT = CMD_ADDR_W'(NUM_OPS);
  localparam logic [VOICE_OPERATOR_ID_W-1:0] LAST_OP   = VOICE_OPERATOR_ID_W'(NUM_OPS - 1);

  disp_state_e                    state;
  logic                           fifoFull;
  logic                           fifoEmpty;
  logic                           push;
  cmd_word_t                      head_p0;
  logic                           vld_p0;
  logic [NUM_VOICES-1:0]          shadow;
  logic [NUM_VOICES-1:0]          voiceBit_p0;
  logic [NUM_VOICES-1:0]          shadowNext_p0;
  logic                           voiceOk_p0;
  logic                           doPhase_p0;
  logic                           doNote_p0;
  logic                           doFill_p0;
  logic                           doClr_p0;
  logic                           isErr_p0;
  logic [VOICE_OPERATOR_ID_W-1:0] fillAddr;
  logic [15:0]                    fillData;
  logic                           phaseWe_p1;
  logic                           noteWe_p1;
  logic [VOICE_OPERATOR_ID_W-1:0] wrAddr_p1;
  logic [15:0]                    wrData_p1;
  logic                           cmdErr;

  assign o_CmdReady = !i_Reset && (state != ST_INIT) && !fifoFull;
  assign push       = i_CmdValid && o_CmdReady;
  assign vld_p0     = (state == ST_IDLE) && !fifoEmpty;
  assign o_Busy     = (state != ST_IDLE) || !fifoEmpty;

  config_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .i_Push    (push),
    .i_PushData(cmd_word_t'(i_CmdData)),
    .i_Pop     (vld_p0),
    .o_PopData (head_p0),
    .o_Full    (fifoFull),
    .o_Empty   (fifoEmpty)
  );

  // p0: decode the FIFO head against the current shadow
  always_comb begin
    voiceBit_p0   = NUM_VOICES'(1) << head_p0.addr[3:0];
    voiceOk_p0    = ({1'b0, head_p0.addr[3:0]} < 5'(NUM_VOICES));
    shadowNext_p0 = shadow;
    doPhase_p0    = 1'b0;
    doNote_p0     = 1'b0;
    doFill_p0     = 1'b0;
    doClr_p0      = 1'b0;
    isErr_p0      = 1'b0;
    case (head_p0.op)
      OP_NOP: ;
      OP_PHASE_STEP: begin
        if (head_p0.addr < OPS_LIMIT) doPhase_p0 = 1'b1;
        else                          isErr_p0   = 1'b1;
      end
      OP_NOTE_ON_SET: begin
        if (voiceOk_p0) begin
          shadowNext_p0 = shadow | voiceBit_p0;
          doNote_p0     = 1'b1;
        end else begin
          isErr_p0 = 1'b1;
        end
      end
      OP_NOTE_ON_CLEAR: begin
        if (voiceOk_p0) begin
          shadowNext_p0 = shadow & ~voiceBit_p0;
          doNote_p0     = 1'b1;
        end else begin
          isErr_p0 = 1'b1;
        end
      end
      OP_NOTE_ON_ALL: begin
        shadowNext_p0 = NUM_VOICES'(head_p0.data[11:0]);
        doNote_p0     = 1'b1;
      end
      OP_PHASE_STEP_FILL: doFill_p0 = 1'b1;
      OP_CLEAR_ERROR:     doClr_p0  = 1'b1;
      default:            isErr_p0  = 1'b1;
    endcase
  end

  // p1: FSM and registered write port
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state      <= ST_INIT;
      shadow     <= '0;
      fillAddr   <= '0;
      phaseWe_p1 <= 1'b0;
      noteWe_p1  <= 1'b0;
      wrAddr_p1  <= '0;
      wrData_p1  <= '0;
      cmdErr     <= 1'b0;
    end else begin
      phaseWe_p1 <= 1'b0;
      noteWe_p1  <= 1'b0;
      case (state)
        ST_INIT: begin
          // Align the receiver with the freshly cleared shadow.
          noteWe_p1 <= 1'b1;
          wrAddr_p1 <= VOICE_OPERATOR_ID_W'(NOTE_ON_ADDR);
          wrData_p1 <= '0;
          state     <= ST_IDLE;
        end
        ST_IDLE: begin
          if (vld_p0) begin
            if (doPhase_p0) begin
              phaseWe_p1 <= 1'b1;
              wrAddr_p1  <= head_p0.addr[VOICE_OPERATOR_ID_W-1:0];
              wrData_p1  <= head_p0.data;
            end
            if (doNote_p0) begin
              noteWe_p1 <= 1'b1;
              wrAddr_p1 <= VOICE_OPERATOR_ID_W'(NOTE_ON_ADDR);
              wrData_p1 <= 16'(shadowNext_p0);
              shadow    <= shadowNext_p0;
            end
            if (doFill_p0) begin
              // Address 0 goes out with the pop; FILL covers the rest.
              phaseWe_p1 <= 1'b1;
              wrAddr_p1  <= '0;
              wrData_p1  <= head_p0.data;
              fillData   <= head_p0.data;
              fillAddr   <= VOICE_OPERATOR_ID_W'(1);
              if (NUM_OPS > 1) state <= ST_FILL;
            end
            if (isErr_p0)      cmdErr <= 1'b1;
            else if (doClr_p0) cmdErr <= 1'b0;
          end
        end
        ST_FILL: begin
          phaseWe_p1 <= 1'b1;
          wrAddr_p1  <= fillAddr;
          wrData_p1  <= fillData;
          if (fillAddr == LAST_OP) state    <= ST_IDLE;
          else                     fillAddr <= fillAddr + 1'b1;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  assign o_PhaseStepConfigWriteEnable = phaseWe_p1;
  assign o_NoteOnConfigWriteEnable    = noteWe_p1;
  assign o_ConfigWriteAddr            = wrAddr_p1;
  assign o_ConfigWriteData            = wrData_p1;
  assign o_CmdError                   = cmdErr;

endmodule

// File: tb/tb_config_write_dispatcher.sv
// Directed plus randomized bench for config_write_dispatcher, checking the
// observed write stream against a command-level reference model.
module tb_config_write_dispatcher;

  localparam int NUM_OPS    = 16;
  localparam int NUM_VOICES = 12;
  localparam int DEPTH      = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmdValid;
  logic        cmdReady;
  logic [31:0] cmdData;
  logic        pWe;
  logic        nWe;
  logic [3:0]  wAddr;
  logic [15:0] wData;
  logic        busy;
  logic        cmdErr;

  int nCompared   = 0;
  int nMismatched = 0;
  int cyc         = 0;

  logic [31:0] obsQ[$];
  int          obsCyc[$];
  logic [31:0] expQ[$];
  int          mShadow;
  bit          mErr;

  config_write_dispatcher #(
    .FIFO_DEPTH(DEPTH),
    .NUM_VOICES(NUM_VOICES),
    .NUM_OPS   (NUM_OPS)
  ) dut (
    .i_Clock                     (clk),
    .i_Reset                     (rst),
    .i_CmdValid                  (cmdValid),
    .o_CmdReady                  (cmdReady),
    .i_CmdData                   (cmdData),
    .o_PhaseStepConfigWriteEnable(pWe),
    .o_NoteOnConfigWriteEnable   (nWe),
    .o_ConfigWriteAddr           (wAddr),
    .o_ConfigWriteData           (wData),
    .o_Busy                      (busy),
    .o_CmdError                  (cmdErr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pack(input int kind, input int addr, input logic [15:0] data);
    logic [31:0] r;
    r = {4'(kind), 12'(addr), data};
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Record every strobe seen on the write port.
  always @(negedge clk) begin
    if (pWe || nWe) begin
      obsQ.push_back(pack(nWe ? 2 : 1, int'(wAddr), wData));
      obsCyc.push_back(cyc);
      check("strobe_mutex", 32'(pWe & nWe), 32'd0);
    end
  end

  task automatic modelReset();
    mShadow = 0;
    mErr    = 1'b0;
    expQ.push_back(pack(2, 0, 16'h0000));
  endtask

  task automatic modelCmd(input logic [31:0] w);
    logic [3:0]  op;
    logic [11:0] a;
    logic [15:0] d;
    int          v;
    op = w[31:28];
    a  = w[27:16];
    d  = w[15:0];
    v  = int'(a[3:0]);
    case (op)
      4'h0: ;
      4'h1: if (int'(a) < NUM_OPS) expQ.push_back(pack(1, int'(a), d)); else mErr = 1'b1;
      4'h2: if (v < NUM_VOICES) begin
              mShadow = mShadow | (1 << v);
              expQ.push_back(pack(2, 0, 16'(mShadow)));
            end else mErr = 1'b1;
      4'h3: if (v < NUM_VOICES) begin
              mShadow = mShadow & ~(1 << v);
              expQ.push_back(pack(2, 0, 16'(mShadow)));
            end else mErr = 1'b1;
      4'h4: begin
              mShadow = int'(d[11:0]);
              expQ.push_back(pack(2, 0, 16'(mShadow)));
            end
      4'h5: for (int i = 0; i < NUM_OPS; i++) expQ.push_back(pack(1, i, d));
      4'hF: mErr = 1'b0;
      default: mErr = 1'b1;
    endcase
  endtask

  task automatic checkStream(input string tag);
    check({tag, "_count"}, 32'(obsQ.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++)
      check($sformatf("%s_w%0d", tag, i), obsQ[i], expQ[i]);
    obsQ.delete();
    obsCyc.delete();
    expQ.delete();
  endtask

  // Holds cmdValid high after the handshake so callers can chain commands.
  task automatic sendCmd(input logic [31:0] w, output int acc, output int stalls);
    int g;
    g        = 0;
    cmdValid = 1'b1;
    cmdData  = w;
    while (!cmdReady && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) check("send_timeout", 32'(cmdReady), 32'd1);
    acc    = cyc;
    stalls = g;
    @(negedge clk);
  endtask

  task automatic waitIdle(input string tag);
    int g;
    g        = 0;
    cmdValid = 1'b0;
    while (busy && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) check({tag, "_idle_timeout"}, 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, observed=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          acc;
    int          st;
    int          totalStalls;
    int          g;
    int          fills;
    logic [31:0] w;
    logic [3:0]  op;
    logic [11:0] a;
    logic [15:0] d;

    rst      = 1'b1;
    cmdValid = 1'b0;
    cmdData  = '0;
    modelReset();

    // Reset values and INIT write
    repeat (3) @(negedge clk);
    check("rst_pwe",   32'(pWe),      32'd0);
    check("rst_nwe",   32'(nWe),      32'd0);
    check("rst_addr",  32'(wAddr),    32'd0);
    check("rst_data",  32'(wData),    32'd0);
    check("rst_err",   32'(cmdErr),   32'd0);
    check("rst_ready", 32'(cmdReady), 32'd0);
    rst = 1'b0;
    #1;
    check("init_ready", 32'(cmdReady), 32'd0);
    check("init_busy",  32'(busy),     32'd1);
    @(negedge clk);
    check("init_nwe",   32'(nWe),      32'd1);
    check("init_pwe",   32'(pWe),      32'd0);
    check("init_ready_up", 32'(cmdReady), 32'd1);
    @(negedge clk);
    check("init_nwe_drop", 32'(nWe),  32'd0);
    check("init_busy_low", 32'(busy), 32'd0);
    checkStream("init");

    // Single PhaseStep: latency, width, hold
    w = 32'h1005_1234;
    sendCmd(w, acc, st);
    modelCmd(w);
    waitIdle("lat");
    if (obsCyc.size() > 0) check("lat_cycle", 32'(obsCyc[0]), 32'(acc + 2));
    check("hold_addr", 32'(wAddr), 32'd5);
    check("hold_data", 32'(wData), 32'h1234);
    check("hold_pwe",  32'(pWe),   32'd0);
    checkStream("lat");

    // SET 3, SET 7, CLEAR 3 back-to-back
    for (int i = 0; i < 3; i++) begin
      w = (i == 0) ? 32'h2003_0000 : (i == 1) ? 32'h2007_0000 : 32'h3003_0000;
      sendCmd(w, acc, st);
      modelCmd(w);
    end
    waitIdle("note");
    if (obsCyc.size() == 3) begin
      check("note_b2b_1", 32'(obsCyc[1] - obsCyc[0]), 32'd1);
      check("note_b2b_2", 32'(obsCyc[2] - obsCyc[1]), 32'd1);
    end
    check("note_w0", obsQ.size() > 0 ? obsQ[0] : 32'hDEAD_BEEF, pack(2, 0, 16'h0008));
    checkStream("note");

    // FILL followed by a burst that overruns the FIFO
    w = 32'h5000_ABCD;
    sendCmd(w, acc, st);
    modelCmd(w);
    totalStalls = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      w = {4'h1, 12'($urandom_range(0, NUM_OPS - 1)), 16'($urandom)};
      sendCmd(w, acc, st);
      modelCmd(w);
      totalStalls += st;
    end
    waitIdle("fill");
    check("fill_ready_low", 32'(totalStalls > 0), 32'd1);
    if (obsCyc.size() == NUM_OPS + DEPTH + 1)
      check("fill_b2b", 32'(obsCyc[NUM_OPS + DEPTH] - obsCyc[0]), 32'(NUM_OPS + DEPTH));
    checkStream("fill");

    // Illegal commands, sticky error, clear
    sendCmd(32'h7000_0000, acc, st); modelCmd(32'h7000_0000);
    sendCmd(32'h200C_0000, acc, st); modelCmd(32'h200C_0000);
    w = {4'h1, 12'(NUM_OPS), 16'h1111};
    sendCmd(w, acc, st); modelCmd(w);
    waitIdle("err");
    check("err_set", 32'(cmdErr), 32'd1);
    checkStream("err_nowrite");
    sendCmd(32'h2002_0000, acc, st); modelCmd(32'h2002_0000);
    waitIdle("err_sticky");
    check("err_sticky", 32'(cmdErr), 32'(mErr));
    checkStream("err_sticky");
    sendCmd(32'hF000_0000, acc, st); modelCmd(32'hF000_0000);
    waitIdle("err_clr");
    check("err_clear", 32'(cmdErr), 32'd0);

    // Randomized mix against the reference model
    fills = 0;
    for (int i = 0; i < 40; i++) begin
      a = 12'($urandom_range(0, 15));
      d = 16'($urandom);
      case ($urandom_range(0, 9))
        0:       op = 4'h0;
        1, 9:    begin op = 4'h1; a = 12'($urandom_range(0, NUM_OPS + 1)); end
        2:       op = 4'h2;
        3:       op = 4'h3;
        4:       op = 4'h4;
        5:       op = (fills < 2) ? 4'h5 : 4'h1;
        6:       op = 4'hF;
        7:       op = 4'($urandom_range(6, 14));
        default: op = 4'h2;
      endcase
      if (op == 4'h5) fills++;
      w = {op, a, d};
      sendCmd(w, acc, st);
      modelCmd(w);
      if ($urandom_range(0, 3) == 0) begin
        cmdValid = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
    end
    waitIdle("rand");
    check("rand_err", 32'(cmdErr), 32'(mErr));
    checkStream("rand");

    // Reset during FILL with commands queued
    sendCmd(32'h5000_5A5A, acc, st);
    sendCmd(32'h1001_0001, acc, st);
    sendCmd(32'h1002_0002, acc, st);
    cmdValid = 1'b0;
    g = 0;
    while (!(pWe && wAddr == 4'd10) && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) check("rfill_reach10", 32'(wAddr), 32'd10);
    for (int i = 0; i <= 10; i++) expQ.push_back(pack(1, i, 16'h5A5A));
    rst = 1'b1;
    @(negedge clk);
    check("rfill_no_pwe", 32'(pWe), 32'd0);
    check("rfill_no_nwe", 32'(nWe), 32'd0);
    rst = 1'b0;
    #1;
    check("rfill_ready_init", 32'(cmdReady), 32'd0);
    modelReset();
    waitIdle("rfill");
    check("rfill_empty", 32'(busy), 32'd0);
    checkStream("rfill");
    sendCmd(32'h2001_0000, acc, st);
    modelCmd(32'h2001_0000);
    waitIdle("rfill_set");
    checkStream("rfill_set");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
